// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide unit and the control decoder.
package md_sequencer_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// E-stage issue / HI-LO readback bundle between the pipeline and the md unit.
interface md_sequencer_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_in_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val, md_in_D,
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, md_in_D,
    output busy, stall_md, hi, lo
  );
endinterface

// File: rtl/md_arith.sv
// Combinational 64-bit product and quotient/remainder from latched operands.
module md_arith
  import md_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Signed ops divide on magnitudes and fix signs afterwards; this keeps
  // 0x80000000 / -1 well defined (magnitude 2^31 fits unsigned 32 bits).
  always_comb begin
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    ext_a     = {(signed_op && a[31]) ? '1 : 32'h0, a};
    ext_b     = {(signed_op && b[31]) ? '1 : 32'h0, b};
    prod      = ext_a * ext_b;

    a_neg     = signed_op & a[31];
    b_neg     = signed_op & b[31];
    mag_a     = a_neg ? (~a + 32'd1) : a;
    mag_b     = b_neg ? (~b + 32'd1) : b;
    div_zero  = (b == '0);
    divisor   = div_zero ? 32'd1 : mag_b;
    q_mag     = mag_a / divisor;
    r_mag     = mag_a % divisor;
    quot      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem       = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the counter, busy and HI/LO.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           reset,
  md_sequencer_if.slave  bus
);

  localparam int unsigned CW = $clog2(max_u(MULT_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    op_q,    op_d;
  logic [31:0]   a_q,     a_d;
  logic [31:0]   b_q,     b_d;
  logic [31:0]   hi_q,    hi_d;
  logic [31:0]   lo_q,    lo_d;

  logic [63:0]   prod;
  logic [31:0]   quot;
  logic [31:0]   rem;
  logic          div_zero;

  md_arith u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  // Next-state: accept when idle, count down when busy, commit on the last count.
  // start is only examined in S_IDLE, so it is dropped on the falling-busy edge too.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.md_op)
            MD_MULT, MD_MULTU: begin
              op_d    = bus.md_op;
              a_d     = bus.rs_val;
              b_d     = bus.rt_val;
              cnt_d   = MULT_LOAD;
              state_d = S_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              op_d    = bus.md_op;
              a_d     = bus.rs_val;
              b_d     = bus.rt_val;
              cnt_d   = DIV_LOAD;
              state_d = S_BUSY;
            end
            MD_MTHI: hi_d = bus.rs_val;
            MD_MTLO: lo_d = bus.rs_val;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          case (op_q)
            MD_MULT, MD_MULTU: begin
              hi_d = prod[63:32];
              lo_d = prod[31:0];
            end
            MD_DIV, MD_DIVU: begin
              if (!div_zero) begin
                hi_d = rem;
                lo_d = quot;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy     = (state_q == S_BUSY);
  assign bus.stall_md = bus.md_in_D & (bus.start | bus.busy);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
